// File: rtl/shift_concat_if.sv
// Bus bundle for the shift_concat bit packer: chunk input side and packed word output side.
// Optional `last` output exists only when SHIFT_CONCAT_LAST_EN is defined.
interface shift_concat_if #(
    parameter int WORD_W = 64,
    parameter int CNT_W  = 7
);
    logic [WORD_W-1:0] data_in;
    logic [CNT_W-1:0]  valid_bits;
    logic              data_valid;
    logic              msg_fin;
    logic [WORD_W-1:0] data_out;
    logic              done;
`ifdef SHIFT_CONCAT_LAST_EN
    logic              last;
`endif

    // Handshake: data_valid/msg_fin are sampled on every rising clk edge with no
    // ready/backpressure; done is a one-cycle strobe marking data_out as a fresh word.
    modport master (
        output data_in, valid_bits, data_valid, msg_fin,
`ifdef SHIFT_CONCAT_LAST_EN
        input  data_out, done, last
`else
        input  data_out, done
`endif
    );

    modport slave (
        input  data_in, valid_bits, data_valid, msg_fin,
`ifdef SHIFT_CONCAT_LAST_EN
        output data_out, done, last
`else
        output data_out, done
`endif
    );
endinterface

// File: rtl/shift_concat.sv
// Bit packer: concatenates 1..WORD_W-bit chunks MSB-first and emits full words; msg_fin
// flushes a left-aligned zero-padded tail. Define SHIFT_CONCAT_LAST_EN to add the `last` output.
module shift_concat #(
    parameter int WORD_W = 64,
    parameter int CNT_W  = 7
) (
    input  logic          clk,
    input  logic          rst,
    shift_concat_if.slave bus
);
    localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WORD_W);

    logic [2*WORD_W-1:0] acc_q, acc_next;
    logic [CNT_W-1:0]    cnt_q, cnt_next, cnt_upd;
    logic                pend_q, pend_next;
    logic [WORD_W-1:0]   out_q, out_next;
    logic                done_q, done_next;
    logic                last_next;
    logic [CNT_W-1:0]    n;
    logic [WORD_W-1:0]   chunk;
    logic                flush_req;

    // Chunk length after clamping; a deasserted data_valid contributes nothing.
    always_comb begin
        n = '0;
        if (bus.data_valid)
            n = (bus.valid_bits > WORD_CNT) ? WORD_CNT : bus.valid_bits;
        // A shift by WORD_W yields zero, so n=0 masks the whole chunk away.
        chunk     = bus.data_in & ({WORD_W{1'b1}} >> (WORD_CNT - n));
        acc_next  = (acc_q << n) | {{WORD_W{1'b0}}, chunk};
        cnt_next  = cnt_q + n;
        flush_req = bus.msg_fin | pend_q;
    end

    // Emission decision: full word first, otherwise a flush of the partial tail.
    always_comb begin
        cnt_upd   = cnt_next;
        pend_next = pend_q;
        out_next  = out_q;
        done_next = 1'b0;
        last_next = 1'b0;
        if (cnt_next >= WORD_CNT) begin
            out_next  = WORD_W'(acc_next >> (cnt_next - WORD_CNT));
            done_next = 1'b1;
            cnt_upd   = cnt_next - WORD_CNT;
            // With no residue the full word already closes the message.
            if (flush_req) begin
                pend_next = (cnt_upd != '0);
                last_next = (cnt_upd == '0);
            end
        end else if (flush_req) begin
            pend_next = 1'b0;
            if (cnt_next != '0) begin
                // Bits above cnt_next fall off the top of the WORD_W-bit result.
                out_next  = WORD_W'(acc_next << (WORD_CNT - cnt_next));
                done_next = 1'b1;
                last_next = 1'b1;
                cnt_upd   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
            out_q  <= '0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_next;
            cnt_q  <= cnt_upd;
            pend_q <= pend_next;
            out_q  <= out_next;
            done_q <= done_next;
        end
    end

    assign bus.data_out = out_q;
    assign bus.done     = done_q;

`ifdef SHIFT_CONCAT_LAST_EN
    logic last_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_q <= 1'b0;
        else      last_q <= last_next;
    end
    assign bus.last = last_q;
`else
    logic unused_last;
    assign unused_last = last_next;
`endif
endmodule

// File: tb/tb_shift_concat.sv
// Self-checking bench for shift_concat: directed known answers plus randomized chunks
// compared against a bit-queue reference model.
module tb_shift_concat;
    logic clk;
    logic rst;

    shift_concat_if #(.WORD_W(64), .CNT_W(7)) sc ();

    shift_concat #(.WORD_W(64), .CNT_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sc)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          bits_q[$];        // bitstream not yet emitted, oldest first
    logic [63:0] exp_q[$];         // words the model expects, in order
    bit          pend     = 1'b0;  // model's outstanding flush request
    logic [63:0] exp_hold = '0;    // value data_out must hold between words

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        bits_q.delete();
        exp_q.delete();
        pend     = 1'b0;
        exp_hold = '0;
    endtask

    // ---------------- driver + model ----------------
    task automatic step(input logic dv, input logic [6:0] vb, input logic [63:0] din,
                        input logic fin);
        int          n;
        logic [63:0] w;
        logic        exp_done;
        logic        exp_last;
        sc.data_valid = dv;
        sc.valid_bits = vb;
        sc.data_in    = din;
        sc.msg_fin    = fin;
        @(posedge clk);
        #1;
        n = dv ? ((vb > 7'd64) ? 64 : int'(vb)) : 0;
        for (int i = n - 1; i >= 0; i--) bits_q.push_back(din[i]);
        exp_done = 1'b0;
        exp_last = 1'b0;
        w        = '0;
        if (bits_q.size() >= 64) begin
            for (int i = 63; i >= 0; i--) w[i] = bits_q.pop_front();
            exp_done = 1'b1;
            if (fin || pend) begin
                pend     = (bits_q.size() != 0);
                exp_last = !pend;
            end
        end else if (fin || pend) begin
            if (bits_q.size() > 0) begin
                for (int i = 63; i >= 0 && bits_q.size() > 0; i--) w[i] = bits_q.pop_front();
                exp_done = 1'b1;
                exp_last = 1'b1;
            end
            pend = 1'b0;
        end
        if (exp_done) begin
            exp_q.push_back(w);
            exp_hold = w;
        end
        check("done", 64'(sc.done), 64'(exp_done));
        if (sc.done && exp_q.size() > 0) check("word", sc.data_out, exp_q.pop_front());
        else                             check("hold", sc.data_out, exp_hold);
        if (!sc.done) exp_q.delete();
`ifdef SHIFT_CONCAT_LAST_EN
        check("last", 64'(sc.last), 64'(exp_last));
`endif
    endtask

    task automatic idle();
        step(1'b0, 7'd0, 64'd0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] r;
        rst           = 1'b0;
        sc.data_in    = '0;
        sc.valid_bits = '0;
        sc.data_valid = 1'b0;
        sc.msg_fin    = 1'b0;
        #12;
        check("rst_done", 64'(sc.done), 64'd0);
        check("rst_data", sc.data_out, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle();

        // Word boundary crossing, then tail flush.
        step(1'b1, 7'd52, 64'h000A_BCDE_F123_4567, 1'b0);
        step(1'b1, 7'd4,  64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        step(1'b1, 7'd16, 64'h1234_5678_9ABC_EBF3, 1'b0);
        check("ka_pack", sc.data_out, 64'hABCDEF1234567EEB);
        step(1'b1, 7'd8, 64'h0000_0000_0000_00EC, 1'b0);
        step(1'b0, 7'd0, 64'd0, 1'b1);
        check("ka_flush", sc.data_out, 64'hF3EC000000000000);
        check("ka_flush_done", 64'(sc.done), 64'd1);

        // Exact fill, then an empty flush.
        step(1'b1, 7'd64, 64'h0123_4567_89AB_CDEF, 1'b0);
        check("ka_exact", sc.data_out, 64'h0123456789ABCDEF);
        step(1'b0, 7'd0, 64'd0, 1'b1);
        check("ka_empty_flush", 64'(sc.done), 64'd0);

        // Double flush.
        step(1'b1, 7'd60, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        step(1'b1, 7'd8,  64'h0000_0000_0000_005A, 1'b1);
        check("ka_dbl1", sc.data_out, 64'hFFFFFFFFFFFFFFF5);
        idle();
        check("ka_dbl2", sc.data_out, 64'hA000000000000000);
        check("ka_dbl2_done", 64'(sc.done), 64'd1);

        // Zero-length chunk leaves state alone; oversize length clamps to 64.
        step(1'b1, 7'd12, 64'h0000_0000_0000_0ABC, 1'b0);
        step(1'b1, 7'd0,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        step(1'b0, 7'd0,  64'd0, 1'b1);
        check("ka_zero_len", sc.data_out, 64'hABC0000000000000);
        r = {$urandom, $urandom};
        step(1'b1, 7'd100, r, 1'b0);
        check("ka_clamp", sc.data_out, r);

        // Asynchronous reset right after a done pulse, away from any edge.
        step(1'b1, 7'd64, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("async_done", 64'(sc.done), 64'd0);
        check("async_data", sc.data_out, 64'd0);
        model_reset();
        rst = 1'b1;

        // Reset mid-message drops buffered bits and the pending flush.
        step(1'b1, 7'd20, 64'h0000_0000_000F_FFFF, 1'b0);
        step(1'b1, 7'd60, 64'h0FFF_FFFF_FFFF_FFFF, 1'b1);
        #2 rst = 1'b0;
        #1;
        model_reset();
        rst = 1'b1;
        step(1'b1, 7'd64, 64'h1357_9BDF_2468_ACE0, 1'b0);
        check("mid_reset", sc.data_out, 64'h13579BDF2468ACE0);

        // Randomized traffic against the model.
        for (int k = 0; k < 2000; k++) begin
            logic       dv;
            logic [6:0] vb;
            logic       fin;
            dv  = ($urandom_range(0, 3) != 0);
            vb  = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127))
                                              : 7'($urandom_range(1, 64));
            fin = ($urandom_range(0, 11) == 0);
            r   = {$urandom, $urandom};
            step(dv, vb, r, fin);
        end
        step(1'b0, 7'd0, 64'd0, 1'b1);
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
